// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 3-sample majority vote per bit, start/stop checks,
// one-word output register with valid/ready and overrun. Parity via UART_RX_PARITY_EN.
module uart_rx_os #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tick_i,
    input  logic              rx_i,
    input  logic              en_i,
    input  logic              parity_odd_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              frame_err_o,
    output logic              parity_err_o,
    output logic              overrun_o,
    output logic              busy_o
);
    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_W + 1);
    localparam int unsigned M  = OVERSAMPLE / 2;

    localparam logic [SW-1:0] SCNT_PRE  = SW'(M - 1);
    localparam logic [SW-1:0] SCNT_MID  = SW'(M);
    localparam logic [SW-1:0] SCNT_DEC  = SW'(M + 1);
    localparam logic [SW-1:0] SCNT_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   armed;
    logic [SW-1:0]          scnt;
    logic [BW-1:0]          bcnt;
    logic                   s_pre;
    logic                   s_mid;
    logic [DATA_W-1:0]      shreg;
    logic                   ferr;
    logic                   vote;
    logic                   at_dec;
    logic                   at_last;
    logic                   word_done;
    logic                   word_ferr;
`ifdef UART_RX_PARITY_EN
    logic                   perr;
`else
    logic                   unused_parity_odd;
    assign unused_parity_odd = parity_odd_i;
    assign parity_err_o      = 1'b0;
`endif

    assign rxs = sync_q[SYNC_STAGES-1];

    always_comb begin
        vote      = (s_pre & s_mid) | (s_pre & rxs) | (s_mid & rxs);
        at_dec    = (scnt == SCNT_DEC);
        at_last   = (scnt == SCNT_LAST);
        word_done = en_i && tick_i && (state == S_STOP) && at_dec && (bcnt == STOP_LAST);
        word_ferr = ferr | ~vote;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end

    // Decision-tick code follows wrap-tick code in each state so that, when both
    // fall on the same tick (small OVERSAMPLE), the decision's transition wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= S_IDLE;
            armed  <= 1'b0;
            scnt   <= '0;
            bcnt   <= '0;
            s_pre  <= 1'b1;
            s_mid  <= 1'b1;
            shreg  <= '0;
            ferr   <= 1'b0;
            busy_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr   <= 1'b0;
`endif
        end else if (!en_i) begin
            state  <= S_IDLE;
            armed  <= 1'b0;
            scnt   <= '0;
            bcnt   <= '0;
            busy_o <= 1'b0;
        end else if (tick_i) begin
            if (state != S_IDLE) scnt <= at_last ? '0 : scnt + SW'(1);
            if (scnt == SCNT_PRE) s_pre <= rxs;
            if (scnt == SCNT_MID) s_mid <= rxs;
            case (state)
                S_IDLE: begin
                    if (rxs) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        state  <= S_START;
                        scnt   <= '0;
                        bcnt   <= '0;
                        ferr   <= 1'b0;
                        busy_o <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr   <= 1'b0;
`endif
                    end
                end
                S_START: begin
                    if (at_last) state <= S_DATA;
                    if (at_dec && vote) begin
                        state  <= S_IDLE;
                        armed  <= 1'b0;
                        scnt   <= '0;
                        busy_o <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (at_dec) shreg <= {vote, shreg[DATA_W-1:1]};
                    if (at_last) begin
                        if (bcnt == DATA_LAST) begin
                            bcnt  <= '0;
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            bcnt <= bcnt + BW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (at_dec) perr <= ((^shreg) ^ vote) != parity_odd_i;
                    if (at_last) state <= S_STOP;
                end
`endif
                S_STOP: begin
                    if (at_last) bcnt <= bcnt + BW'(1);
                    if (at_dec) begin
                        if (!vote) ferr <= 1'b1;
                        if (bcnt == STOP_LAST) begin
                            state  <= S_IDLE;
                            armed  <= 1'b0;
                            scnt   <= '0;
                            bcnt   <= '0;
                            busy_o <= 1'b0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o       <= '0;
            valid_o      <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_o <= 1'b0;
`endif
        end else begin
            overrun_o <= 1'b0;
            if (valid_o && ready_i) valid_o <= 1'b0;
            if (word_done) begin
                if (!valid_o || ready_i) begin
                    data_o       <= shreg;
                    frame_err_o  <= word_ferr;
                    valid_o      <= 1'b1;
`ifdef UART_RX_PARITY_EN
                    parity_err_o <= perr;
`endif
                end else begin
                    overrun_o <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// Randomized self-checking bench for uart_rx_os; expected words come from a
// frame-level model (queue of data/flags) built from the bits the bench transmits.
module tb_uart_rx_os;
    localparam int DATA_W    = 8;
    localparam int OS        = 16;
    localparam int STOP_BITS = 1;
    localparam int SYNC      = 2;
`ifdef UART_RX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    // edges from first rx_i drive to valid_o high, tick every cycle
    localparam int LAT = SYNC + 3 + OS / 2 + OS * (DATA_W + NPAR + STOP_BITS);

    logic              clk = 1'b0;
    logic              rst_i, rx_i, en_i, parity_odd_i, ready_i;
    logic              tick_i = 1'b0;
    logic [DATA_W-1:0] data_o;
    logic              valid_o, frame_err_o, parity_err_o, overrun_o, busy_o;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              fe;
        logic              pe;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_words  = 0;
    int          n_ovr    = 0;
    int          tick_div = 1;
    int          tcnt     = 0;
    int unsigned cyc      = 0;
    int unsigned frame_start_cyc = 0;
    int unsigned last_valid_cyc  = 0;

    uart_rx_os #(
        .DATA_W(DATA_W), .OVERSAMPLE(OS), .STOP_BITS(STOP_BITS), .SYNC_STAGES(SYNC)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .tick_i(tick_i), .rx_i(rx_i), .en_i(en_i),
        .parity_odd_i(parity_odd_i), .data_o(data_o), .valid_o(valid_o),
        .ready_i(ready_i), .frame_err_o(frame_err_o), .parity_err_o(parity_err_o),
        .overrun_o(overrun_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tcnt >= tick_div - 1) begin
            tcnt   <= 0;
            tick_i <= 1'b1;
        end else begin
            tcnt   <= tcnt + 1;
            tick_i <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_perr(input logic [DATA_W-1:0] d, input logic pbit, input logic odd);
`ifdef UART_RX_PARITY_EN
        return ((^d) ^ pbit) != odd;
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst_i && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'(data_o), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("data", 32'(data_o), 32'(e.d));
                check("frame_err", 32'(frame_err_o), 32'(e.fe));
                check("parity_err", 32'(parity_err_o), 32'(e.pe));
            end
            n_words++;
            last_valid_cyc = cyc;
        end
        if (overrun_o) n_ovr++;
    end

    task automatic line(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
            rx_i = lvl;
        end
    endtask

    // abort_kind: 0 none, 1 reset pulse, 2 enable drop, at cycle abort_at of the frame
    task automatic send_frame(input logic [DATA_W-1:0] d, input logic [STOP_BITS-1:0] stop_v,
                              input logic pbit, input int glitch_bit,
                              input int abort_at, input int abort_kind);
        logic bits[$];
        int   bit_cyc;
        int   idx;
        bits.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) bits.push_back(d[i]);
        if (NPAR == 1) bits.push_back(pbit);
        for (int i = 0; i < STOP_BITS; i++) bits.push_back(stop_v[i]);
        bit_cyc = OS * tick_div;
        idx     = 0;
        foreach (bits[b]) begin
            for (int c = 0; c < bit_cyc; c++) begin
                @(posedge clk); #2;
                if (idx == 0) frame_start_cyc = cyc;
                rx_i = (b == glitch_bit && c >= 9 * tick_div && c < 10 * tick_div) ? ~bits[b] : bits[b];
                if (abort_kind != 0 && idx == abort_at) begin
                    if (abort_kind == 1) rst_i = 1'b1;
                    else                 en_i  = 1'b0;
                    @(posedge clk); #2;
                    rst_i = 1'b0;
                    en_i  = 1'b1;
                    rx_i  = 1'b1;
                    @(negedge clk);
                    check(abort_kind == 1 ? "rst_busy" : "en_busy", 32'(busy_o), 32'd0);
                    if (abort_kind == 1) check("rst_valid", 32'(valid_o), 32'd0);
                    return;
                end
                idx++;
            end
        end
    endtask

    task automatic expect_frame(input logic [DATA_W-1:0] d, input logic [STOP_BITS-1:0] stop_v,
                                input logic pbit);
        exp_t e;
        e.d  = d;
        e.fe = ~(&stop_v);
        e.pe = exp_perr(d, pbit, parity_odd_i);
        exp_q.push_back(e);
    endtask

    initial begin
        int   w0, o0, gap, gb;
        logic [DATA_W-1:0] d;
        logic [STOP_BITS-1:0] sv;
        logic pb;

        rst_i = 1'b1; en_i = 1'b1; ready_i = 1'b1; rx_i = 1'b1; parity_odd_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_overrun", 32'(overrun_o), 32'd0);
        check("rst_ferr", 32'(frame_err_o), 32'd0);
        check("rst_perr", 32'(parity_err_o), 32'd0);
        @(posedge clk); #2;
        rst_i = 1'b0;
        line(1'b1, 20);

        // clean 0xA5, latency, then with one corrupted mid-bit sample on bit 3
        w0 = n_words;
        pb = ^8'hA5 ^ parity_odd_i;
        expect_frame(8'hA5, '1, pb);
        send_frame(8'hA5, '1, pb, -1, 0, 0);
        line(1'b1, 40);
        check("a5_count", 32'(n_words - w0), 32'd1);
        check("a5_latency", last_valid_cyc - frame_start_cyc, 32'(LAT));
        expect_frame(8'hA5, '1, pb);
        send_frame(8'hA5, '1, pb, 4, 0, 0);
        line(1'b1, 40);
        check("a5_glitch_count", 32'(n_words - w0), 32'd2);

        // false start
        w0 = n_words;
        line(1'b0, 4);
        @(negedge clk);
        check("false_start_busy_hi", 32'(busy_o), 32'd1);
        line(1'b1, 12);
        @(negedge clk);
        check("false_start_busy_lo", 32'(busy_o), 32'd0);
        line(1'b1, 40);
        check("false_start_words", 32'(n_words - w0), 32'd0);

        // frame error, then line held low for 30 bit times
        w0 = n_words;
        pb = ^8'h3C ^ parity_odd_i;
        expect_frame(8'h3C, '0, pb);
        send_frame(8'h3C, '0, pb, -1, 0, 0);
        line(1'b0, 30 * OS);
        @(negedge clk);
        check("break_words", 32'(n_words - w0), 32'd1);
        check("break_busy", 32'(busy_o), 32'd0);
        line(1'b1, 3 * OS);

        // overrun with ready low
        w0 = n_words; o0 = n_ovr;
        @(posedge clk); #2;
        ready_i = 1'b0;
        expect_frame(8'h11, '1, ^8'h11 ^ parity_odd_i);
        send_frame(8'h11, '1, ^8'h11 ^ parity_odd_i, -1, 0, 0);
        line(1'b1, 20);
        send_frame(8'h22, '1, ^8'h22 ^ parity_odd_i, -1, 0, 0);
        line(1'b1, 40);
        @(negedge clk);
        check("ovr_valid_held", 32'(valid_o), 32'd1);
        check("ovr_data_held", 32'(data_o), 32'h11);
        check("ovr_pulses", 32'(n_ovr - o0), 32'd1);
        @(posedge clk); #2;
        ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ovr_valid_clear", 32'(valid_o), 32'd0);
        check("ovr_words", 32'(n_words - w0), 32'd1);

`ifdef UART_RX_PARITY_EN
        parity_odd_i = 1'b0;
        expect_frame(8'h07, '1, 1'b0);
        send_frame(8'h07, '1, 1'b0, -1, 0, 0);
        line(1'b1, 40);
        expect_frame(8'h07, '1, 1'b1);
        send_frame(8'h07, '1, 1'b1, -1, 0, 0);
        line(1'b1, 40);
`endif

        // reset and enable drop during data bit 3, each followed by a clean frame
        send_frame(8'hFF, '1, 1'b0, -1, 4 * OS + OS / 2, 1);
        line(1'b1, 2 * OS);
        expect_frame(8'h5A, '1, ^8'h5A ^ parity_odd_i);
        send_frame(8'h5A, '1, ^8'h5A ^ parity_odd_i, -1, 0, 0);
        line(1'b1, 40);
        send_frame(8'h96, '1, 1'b0, -1, 4 * OS + OS / 2, 2);
        line(1'b1, 2 * OS);

        // randomized frames across tick rates
        for (int i = 0; i < 24; i++) begin
            if (i % 8 == 0) tick_div = int'($urandom_range(3, 1));
            parity_odd_i = 1'($urandom);
            d  = DATA_W'($urandom);
            sv = '1;
            for (int s = 0; s < STOP_BITS; s++) if ($urandom_range(4, 0) == 0) sv[s] = 1'b0;
            pb = (^d) ^ parity_odd_i ^ ($urandom_range(3, 0) == 0);
            gb = ($urandom_range(2, 0) == 0) ? int'($urandom_range(DATA_W + NPAR + STOP_BITS, 0)) : -1;
            expect_frame(d, sv, pb);
            send_frame(d, sv, pb, gb, 0, 0);
            gap = int'($urandom_range(OS * tick_div, 0));
            if (sv != '1) gap = gap + 2 * OS * tick_div;
            line(1'b1, gap + 1);
        end

        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
        check("total_overruns", 32'(n_ovr), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
